// File: rtl/cic_pkg.sv
// cic_pkg: shared constants, output-width helper and default sample type for the CIC decimator.
package cic_pkg;
   localparam int CIC_ORDER = 3;
   localparam int CIC_DEF_OUT_W = 18;
   function automatic int cic_out_w(input int in_w, input int decim);
      return in_w + CIC_ORDER * $clog2(decim);
   endfunction
   typedef logic signed [CIC_DEF_OUT_W-1:0] cic_sample_t;
endpackage

// File: rtl/cic_integrator.sv
// cic_integrator: enabled modular accumulator; wrap-around is intended and never saturates.
module cic_integrator
   import cic_pkg::*;
#(
   parameter int W = CIC_DEF_OUT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic [W-1:0] in_i,
   output logic [W-1:0] acc_o
);
   logic [W-1:0] acc_q, acc_d;
   always_comb acc_d = acc_q + in_i;
   always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else if (en_i) acc_q <= acc_d;
   end
   assign acc_o = acc_q;
endmodule

// File: rtl/cic_decimator.sv
// cic_decimator: third-order CIC, decimate by DECIM, full-precision result behind valid/ready.
module cic_decimator
   import cic_pkg::*;
#(
   parameter int DECIM = 8,
   parameter int IN_W  = 9,
   parameter int OUT_W = cic_out_w(IN_W, DECIM)
) (
   input  logic                    CLK_24M,
   input  logic                    reset,
   input  logic                    enable_3M,
   input  logic signed [IN_W-1:0]  in_data,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overrun
);
   localparam int PW = $clog2(DECIM);
   logic [PW-1:0] ph_q, ph_d;
   logic dec_q;
   logic [OUT_W-1:0] x, in2, in3, acc1, acc2, acc3;
   logic [OUT_W-1:0] c1, c2, c3, d1_q, d2_q, d3_q;
   // Each stage is fed the sum it would see after the previous stage updates, so
   // the cascade adds no sample delay and result m lands exactly on y[DECIM*m-1].
   always_comb begin
      x = OUT_W'(in_data);
      in2 = x + acc1;
      in3 = in2 + acc2;
      ph_d = ph_q + 1'b1;
      c1 = acc3 - d1_q;
      c2 = c1 - d2_q;
      c3 = c2 - d3_q;
   end
   cic_integrator #(.W(OUT_W)) u_int1 (.clk(CLK_24M), .rst(reset), .en_i(enable_3M), .in_i(x),   .acc_o(acc1));
   cic_integrator #(.W(OUT_W)) u_int2 (.clk(CLK_24M), .rst(reset), .en_i(enable_3M), .in_i(in2), .acc_o(acc2));
   cic_integrator #(.W(OUT_W)) u_int3 (.clk(CLK_24M), .rst(reset), .en_i(enable_3M), .in_i(in3), .acc_o(acc3));
   always_ff @(posedge CLK_24M) begin
      if (reset) begin
         ph_q <= '0;
         dec_q <= 1'b0;
         d1_q <= '0;
         d2_q <= '0;
         d3_q <= '0;
         out_data <= '0;
         out_valid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         dec_q <= enable_3M && (ph_q == PW'(DECIM - 1));
         if (enable_3M) ph_q <= ph_d;
         if (dec_q) begin
            d1_q <= acc3;
            d2_q <= c1;
            d3_q <= c2;
            out_data <= c3;
         end
         out_valid <= dec_q | (out_valid & ~out_ready);
         overrun <= overrun | (dec_q & out_valid & ~out_ready);
      end
   end
endmodule
